// File: rtl/dbus_arbiter_if.sv
// D-bus signal bundle shared by the two masters, the arbiter and the interconnect input.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface dbus_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_we;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m0_err;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_we;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic        m1_err;

  logic        s_req;
  logic [31:0] s_addr;
  logic        s_we;
  logic [3:0]  s_wstrb;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_ack;

  logic [1:0]  grant;
  logic        busy;

  modport slave (
    input  m0_req, m0_addr, m0_we, m0_wstrb, m0_wdata,
    input  m1_req, m1_addr, m1_we, m1_wstrb, m1_wdata,
    input  s_rdata, s_ack,
    output m0_rdata, m0_ack, m0_err,
    output m1_rdata, m1_ack, m1_err,
    output s_req, s_addr, s_we, s_wstrb, s_wdata,
    output grant, busy
  );

  modport master (
    output m0_req, m0_addr, m0_we, m0_wstrb, m0_wdata,
    output m1_req, m1_addr, m1_we, m1_wstrb, m1_wdata,
    output s_rdata, s_ack,
    input  m0_rdata, m0_ack, m0_err,
    input  m1_rdata, m1_ack, m1_err,
    input  s_req, s_addr, s_we, s_wstrb, s_wdata,
    input  grant, busy
  );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-master D-bus arbiter (core = master 0, debug module = master 1) with a watchdog
// that aborts transactions the slave never acknowledges.
module dbus_arbiter #(
  parameter     PRIORITY = "RR",
  parameter int TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          rst,
  dbus_arbiter_if.slave bus
);

  localparam bit              DmMode = (PRIORITY == "DM");
  localparam bit              WdEn   = (TIMEOUT > 0);
  localparam int              CntW   = WdEn ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            ownM1;
  logic            selReq;
  logic            ack;
  logic            err;
  logic [31:0]     rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    ownM1       = (state_q == OWN1);
    selReq      = ownM1 ? bus.m1_req : bus.m0_req;
    ack         = 1'b0;
    err         = 1'b0;
    rdata       = '0;
    bus.s_req   = 1'b0;
    bus.s_addr  = '0;
    bus.s_we    = 1'b0;
    bus.s_wstrb = '0;
    bus.s_wdata = '0;
    bus.grant   = 2'b00;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.m0_req && bus.m1_req) begin
          // last_q == 1 means master 1 was served last, so master 0 wins the RR tie
          state_d = (DmMode || !last_q) ? OWN1 : OWN0;
        end else if (bus.m0_req) begin
          state_d = OWN0;
        end else if (bus.m1_req) begin
          state_d = OWN1;
        end
      end

      OWN0, OWN1: begin
        bus.grant   = ownM1 ? 2'b10 : 2'b01;
        bus.s_req   = selReq;
        bus.s_addr  = ownM1 ? bus.m1_addr  : bus.m0_addr;
        bus.s_we    = ownM1 ? bus.m1_we    : bus.m0_we;
        bus.s_wstrb = ownM1 ? bus.m1_wstrb : bus.m0_wstrb;
        bus.s_wdata = ownM1 ? bus.m1_wdata : bus.m0_wdata;
        // A withdrawn request ends ownership silently, even if the slave or watchdog fires
        if (!selReq) begin
          state_d = IDLE;
          last_d  = ownM1;
        end else if (bus.s_ack) begin
          ack     = 1'b1;
          rdata   = bus.s_rdata;
          state_d = IDLE;
          last_d  = ownM1;
        end else if (WdEn && (cnt_q == CntMax)) begin
          ack       = 1'b1;
          err       = 1'b1;
          bus.s_req = 1'b0;
          state_d   = IDLE;
          last_d    = ownM1;
        end else if (WdEn) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    bus.busy     = |bus.grant;
    bus.m0_ack   = ack & ~ownM1;
    bus.m0_err   = err & ~ownM1;
    bus.m0_rdata = ownM1 ? '0 : rdata;
    bus.m1_ack   = ack & ownM1;
    bus.m1_err   = err & ownM1;
    bus.m1_rdata = ownM1 ? rdata : '0;

    // Every output is forced low for the whole reset cycle, whatever the old state was
    if (rst) begin
      bus.s_req    = 1'b0;
      bus.s_addr   = '0;
      bus.s_we     = 1'b0;
      bus.s_wstrb  = '0;
      bus.s_wdata  = '0;
      bus.grant    = 2'b00;
      bus.busy     = 1'b0;
      bus.m0_ack   = 1'b0;
      bus.m0_err   = 1'b0;
      bus.m0_rdata = '0;
      bus.m1_ack   = 1'b0;
      bus.m1_err   = 1'b0;
      bus.m1_rdata = '0;
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized bench for dbus_arbiter: an RR and a DM instance share one stimulus stream,
// a transaction-level reference model feeds scoreboard queues that a negedge monitor drains.
module tb_dbus_arbiter;

  localparam int Timeout   = 8;
  localparam int NumCycles = 3000;

  typedef struct {
    logic [1:0]  grant;
    logic        sReq;
    logic        chkFields;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } cycExp_t;

  typedef struct {
    int          master;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } compExp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mReq;
  logic [31:0] mAddr  [2];
  logic        mWe    [2];
  logic [3:0]  mWstrb [2];
  logic [31:0] mWdata [2];
  logic        sAck;
  logic [31:0] sRdata;

  always #5 clk = ~clk;

  dbus_arbiter_if busRr();
  dbus_arbiter_if busDm();

  assign busRr.m0_req = mReq[0];   assign busRr.m1_req = mReq[1];
  assign busRr.m0_addr = mAddr[0]; assign busRr.m1_addr = mAddr[1];
  assign busRr.m0_we = mWe[0];     assign busRr.m1_we = mWe[1];
  assign busRr.m0_wstrb = mWstrb[0]; assign busRr.m1_wstrb = mWstrb[1];
  assign busRr.m0_wdata = mWdata[0]; assign busRr.m1_wdata = mWdata[1];
  assign busRr.s_ack = sAck;       assign busRr.s_rdata = sRdata;

  assign busDm.m0_req = mReq[0];   assign busDm.m1_req = mReq[1];
  assign busDm.m0_addr = mAddr[0]; assign busDm.m1_addr = mAddr[1];
  assign busDm.m0_we = mWe[0];     assign busDm.m1_we = mWe[1];
  assign busDm.m0_wstrb = mWstrb[0]; assign busDm.m1_wstrb = mWstrb[1];
  assign busDm.m0_wdata = mWdata[0]; assign busDm.m1_wdata = mWdata[1];
  assign busDm.s_ack = sAck;       assign busDm.s_rdata = sRdata;

  dbus_arbiter #(.PRIORITY("RR"), .TIMEOUT(Timeout)) uRr (
    .clk (clk),
    .rst (rst),
    .bus (busRr.slave)
  );

  dbus_arbiter #(.PRIORITY("DM"), .TIMEOUT(Timeout)) uDm (
    .clk (clk),
    .rst (rst),
    .bus (busDm.slave)
  );

  cycExp_t  cycQ0[$];
  cycExp_t  cycQ1[$];
  compExp_t compQ0[$];
  compExp_t compQ1[$];

  int   checks = 0;
  int   errors = 0;
  int   cycNow = 0;
  bit   monOn  = 1'b0;

  // reference model: owner -1 = nobody, waited = cycles owned without completion
  int   owner  [2];
  int   waited [2];
  logic last   [2];

  bit          active [2];
  logic [31:0] tAddr  [2];
  logic        tWe    [2];
  logic [3:0]  tWstrb [2];
  logic [31:0] tWdata [2];
  logic [1:0]  prevReq;
  int          stall;

  task automatic compare(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got 0x%08h, expected 0x%08h", name, d, cycNow, act, exp);
    end
  endtask

  task automatic failNow(input string name, input int d);
    checks++;
    errors++;
    $display("[TB] FAIL %s dut%0d cycle %0d: got none, expected an entry", name, d, cycNow);
  endtask

  task automatic pushComp(input int d, input int x, input logic e, input logic [31:0] rd);
    compExp_t c;
    c.master = x;
    c.err    = e;
    c.rdata  = rd;
    c.cyc    = cycNow;
    if (d == 0) compQ0.push_back(c);
    else        compQ1.push_back(c);
  endtask

  // Advances one model by a cycle of the current inputs and queues what the DUT must show
  task automatic modelStep(input int d, input bit dm, output logic [1:0] acked);
    cycExp_t e;
    int      x;
    e.grant     = 2'b00;
    e.sReq      = 1'b0;
    e.chkFields = 1'b0;
    e.addr      = '0;
    e.we        = 1'b0;
    e.wstrb     = '0;
    e.wdata     = '0;
    acked       = 2'b00;
    if (rst) begin
      e.chkFields = 1'b1;
      owner[d]    = -1;
      waited[d]   = 0;
      last[d]     = 1'b1;
    end else if (owner[d] < 0) begin
      if (mReq == 2'b11) owner[d] = dm ? 1 : (last[d] ? 0 : 1);
      else if (mReq[0])  owner[d] = 0;
      else if (mReq[1])  owner[d] = 1;
      waited[d] = 0;
    end else begin
      x           = owner[d];
      e.grant     = (x == 1) ? 2'b10 : 2'b01;
      e.chkFields = 1'b1;
      e.addr      = mAddr[x];
      e.we        = mWe[x];
      e.wstrb     = mWstrb[x];
      e.wdata     = mWdata[x];
      e.sReq      = mReq[x];
      if (!mReq[x]) begin
        owner[d] = -1;
        last[d]  = (x == 1);
      end else if (sAck) begin
        pushComp(d, x, 1'b0, sRdata);
        acked[x] = 1'b1;
        owner[d] = -1;
        last[d]  = (x == 1);
      end else if (waited[d] == Timeout) begin
        e.sReq = 1'b0;
        pushComp(d, x, 1'b1, 32'h0);
        acked[x] = 1'b1;
        owner[d] = -1;
        last[d]  = (x == 1);
      end else begin
        waited[d]++;
      end
    end
    if (d == 0) cycQ0.push_back(e);
    else        cycQ1.push_back(e);
  endtask

  task automatic applyStimulus(input int i);
    logic [1:0] ackRr;
    logic [1:0] ackDm;
    logic [1:0] drop;
    rst = (i < 3) || (i > 200 && $urandom_range(0, 149) == 0);
    for (int m = 0; m < 2; m++) begin
      if (!active[m] && $urandom_range(0, 3) == 0) begin
        active[m] = 1'b1;
        tAddr[m]  = $urandom;
        tWe[m]    = 1'($urandom_range(0, 1));
        tWstrb[m] = 4'($urandom_range(0, 15));
        tWdata[m] = $urandom;
      end else if (active[m] && $urandom_range(0, 59) == 0) begin
        active[m] = 1'b0;
      end
      mReq[m]   = active[m];
      mAddr[m]  = active[m] ? tAddr[m]  : $urandom;
      mWe[m]    = active[m] ? tWe[m]    : 1'($urandom_range(0, 1));
      mWstrb[m] = active[m] ? tWstrb[m] : 4'($urandom_range(0, 15));
      mWdata[m] = active[m] ? tWdata[m] : $urandom;
    end
    drop = prevReq & ~mReq;
    if (stall > 0) begin
      stall--;
      sAck = 1'b0;
    end else begin
      if ($urandom_range(0, 24) == 0) stall = $urandom_range(5, 14);
      sAck = ($urandom_range(0, 2) == 0);
    end
    if (drop != 2'b00) sAck = 1'b0;
    sRdata = $urandom;
    modelStep(0, 1'b0, ackRr);
    modelStep(1, 1'b1, ackDm);
    for (int m = 0; m < 2; m++) begin
      if (rst || ackRr[m]) active[m] = 1'b0;
    end
    prevReq = mReq;
  endtask

  task automatic checkOutput(input int d, input logic [1:0] grant, input logic busy, input logic sReq,
                             input logic [31:0] addr, input logic we, input logic [3:0] wstrb,
                             input logic [31:0] wdata, input logic [1:0] ack, input logic [1:0] err,
                             input logic [31:0] rd0, input logic [31:0] rd1);
    cycExp_t     e;
    compExp_t    c;
    logic [31:0] rd;
    bit          empty;
    empty = (d == 0) ? (cycQ0.size() == 0) : (cycQ1.size() == 0);
    if (empty) begin
      failNow("cycle-queue", d);
    end else begin
      e = (d == 0) ? cycQ0.pop_front() : cycQ1.pop_front();
      compare("grant", d, 32'(grant), 32'(e.grant));
      compare("busy", d, 32'(busy), 32'(|e.grant));
      compare("s_req", d, 32'(sReq), 32'(e.sReq));
      if (e.chkFields) begin
        compare("s_addr", d, addr, e.addr);
        compare("s_we", d, 32'(we), 32'(e.we));
        compare("s_wstrb", d, 32'(wstrb), 32'(e.wstrb));
        compare("s_wdata", d, wdata, e.wdata);
      end
    end
    for (int m = 0; m < 2; m++) begin
      rd = (m == 0) ? rd0 : rd1;
      if (ack[m]) begin
        empty = (d == 0) ? (compQ0.size() == 0) : (compQ1.size() == 0);
        if (empty) begin
          failNow("unexpected-ack", d);
        end else begin
          c = (d == 0) ? compQ0.pop_front() : compQ1.pop_front();
          compare("ack-master", d, 32'(m), 32'(c.master));
          compare("ack-cycle", d, 32'(cycNow), 32'(c.cyc));
          compare("ack-err", d, 32'(err[m]), 32'(c.err));
          compare("ack-rdata", d, rd, c.rdata);
        end
      end else begin
        compare("err-without-ack", d, 32'(err[m]), 32'h0);
        compare("rdata-without-ack", d, rd, 32'h0);
      end
    end
    if (d == 0 && compQ0.size() != 0 && compQ0[0].cyc < cycNow) begin
      failNow("missed-ack", d);
      void'(compQ0.pop_front());
    end
    if (d == 1 && compQ1.size() != 0 && compQ1[0].cyc < cycNow) begin
      failNow("missed-ack", d);
      void'(compQ1.pop_front());
    end
  endtask

  // Monitor: samples both instances mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (monOn) begin
      checkOutput(0, busRr.grant, busRr.busy, busRr.s_req, busRr.s_addr, busRr.s_we,
                  busRr.s_wstrb, busRr.s_wdata, {busRr.m1_ack, busRr.m0_ack},
                  {busRr.m1_err, busRr.m0_err}, busRr.m0_rdata, busRr.m1_rdata);
      checkOutput(1, busDm.grant, busDm.busy, busDm.s_req, busDm.s_addr, busDm.s_we,
                  busDm.s_wstrb, busDm.s_wdata, {busDm.m1_ack, busDm.m0_ack},
                  {busDm.m1_err, busDm.m0_err}, busDm.m0_rdata, busDm.m1_rdata);
    end
  end

  initial begin
    rst     = 1'b1;
    mReq    = 2'b00;
    sAck    = 1'b0;
    sRdata  = '0;
    prevReq = 2'b00;
    stall   = 0;
    for (int m = 0; m < 2; m++) begin
      owner[m]  = -1;
      waited[m] = 0;
      last[m]   = 1'b1;
      active[m] = 1'b0;
      mAddr[m]  = '0;
      mWe[m]    = 1'b0;
      mWstrb[m] = '0;
      mWdata[m] = '0;
    end
    $display("[TB] starting randomized run of %0d cycles", NumCycles);
    for (int i = 0; i < NumCycles; i++) begin
      @(posedge clk);
      #1;
      cycNow = i;
      applyStimulus(i);
      monOn = 1'b1;
    end
    @(negedge clk);
    #1;
    monOn = 1'b0;
    compare("leftover-acks", 0, 32'(compQ0.size()), 32'h0);
    compare("leftover-acks", 1, 32'(compQ1.size()), 32'h0);
    compare("leftover-cycles", 0, 32'(cycQ0.size()), 32'h0);
    compare("leftover-cycles", 1, 32'(cycQ1.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
